// File: rtl/tx_rx_pkg.sv
// Shared 4-ASK definitions for the transmit source and the receiver slicer/mapper:
// level constants, Gray map, phase width and LFSR taps.
package tx_rx_pkg;

    localparam int unsigned PHASE_W    = 4;
    localparam int unsigned LFSR_W     = 22;
    // Fibonacci taps for x^22 + x^21 + 1 (bit indices of a left-shifting register)
    localparam int unsigned LFSR_TAP_A = 21;
    localparam int unsigned LFSR_TAP_B = 20;
    localparam int unsigned SAMPLE_W   = 18;
    localparam int unsigned SCALE_W    = 3;

    // 1s17 levels: 0.25 and 0.75 of full scale
    localparam logic signed [SAMPLE_W-1:0] LEVEL_INNER = 18'sd32768;
    localparam logic signed [SAMPLE_W-1:0] LEVEL_OUTER = 18'sd98304;

    typedef enum logic [1:0] {
        GRAY_NEG_OUTER = 2'b00,
        GRAY_NEG_INNER = 2'b01,
        GRAY_POS_INNER = 2'b11,
        GRAY_POS_OUTER = 2'b10
    } gray_sym_t;

    // Gray bits to signed amplitude; adjacent levels differ in one bit
    function automatic logic signed [SAMPLE_W-1:0] gray_to_level(input logic [1:0] bits);
        logic signed [SAMPLE_W-1:0] level;
        case (gray_sym_t'(bits))
            GRAY_NEG_OUTER: level = -LEVEL_OUTER;
            GRAY_NEG_INNER: level = -LEVEL_INNER;
            GRAY_POS_INNER: level = LEVEL_INNER;
            default:        level = LEVEL_OUTER;
        endcase
        return level;
    endfunction

    // One Fibonacci step: shift left, feedback enters at bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/lfsr_2step.sv
// 22-bit Fibonacci LFSR advancing two steps per request, with all-zero lock-up guard.
module lfsr_2step import tx_rx_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = '1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [1:0] next_bits_c
);

    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] one_step;
    logic [LFSR_W-1:0] two_step;

    // Two chained steps; the bits shifted out are the top bit before each step
    always_comb begin
        one_step    = lfsr_next(state);
        two_step    = lfsr_next(one_step);
        next_bits_c = {state[LFSR_TAP_A], one_step[LFSR_TAP_A]};
    end

    // State register: reset/lock-up reload take priority over stepping
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEED;
        end else if (state == '0) begin
            state <= SEED;
        end else if (step) begin
            state <= two_step;
        end
    end

endmodule

// File: rtl/tx_4ask_source.sv
// 4-ASK symbol source: phase/enable pulse generation, LFSR symbol bits, Gray
// mapping with scale shift, and block counting.
// Build option: define TX_ZERO_STUFF_EN for zero-stuffed upsampling by 4;
// otherwise each symbol value is held for all four samples.
module tx_4ask_source import tx_rx_pkg::*; #(
    parameter logic [LFSR_W-1:0] LFSR_SEED = 22'h3FFFFF,
    parameter int unsigned       SYM_CNT_W = 20
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [SCALE_W-1:0]         scale,
    output logic                       sam_clk_en,
    output logic                       sym_clk_en,
    output logic [1:0]                 sym_bits,
    output logic signed [SAMPLE_W-1:0] x_out,
    output logic                       block_done
);

    localparam logic [PHASE_W-1:0]   PHASE_LAST = '1;
    localparam logic [SYM_CNT_W-1:0] CNT_LAST   = '1;

    logic [PHASE_W-1:0]   phase;
    logic [SYM_CNT_W-1:0] sym_cnt;
    // Pending flags carry a sample/symbol boundary across an enable-low freeze
    logic                 sam_pend;
    logic                 sym_pend;
    logic [1:0]           next_bits;
    logic                 sam_edge;
    logic                 sym_edge;

    lfsr_2step #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk         (sys_clk),
        .reset       (reset),
        .step        (enable && sym_pend),
        .next_bits_c (next_bits)
    );

    // Boundary decode from the current phase
    always_comb begin
        sam_edge = (phase[1:0] == 2'b11);
        sym_edge = (phase == PHASE_LAST);
    end

    // Phase, pulses, block count and sample output; everything holds while disabled
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            phase      <= '0;
            sym_cnt    <= '0;
            sam_pend   <= 1'b0;
            sym_pend   <= 1'b0;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
            block_done <= 1'b0;
            sym_bits   <= 2'b00;
            x_out      <= '0;
        end else if (enable) begin
            phase      <= phase + PHASE_W'(1);
            sam_pend   <= sam_edge;
            sym_pend   <= sym_edge;
            sam_clk_en <= sam_edge;
            sym_clk_en <= sym_edge;
            block_done <= sym_edge && (sym_cnt == CNT_LAST);
            if (sym_edge) begin
                sym_cnt <= sym_cnt + SYM_CNT_W'(1);
            end
            if (sym_pend) begin
                sym_bits <= next_bits;
                x_out    <= gray_to_level(next_bits) >>> scale;
            end
`ifdef TX_ZERO_STUFF_EN
            else if (sam_pend) begin
                x_out <= '0;
            end
`endif
        end else begin
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
            block_done <= 1'b0;
        end
    end

endmodule
